dmem_access_unit: RTL and testbench

- Load/store front-end sitting directly upstream of the data memory in the multicycle CPU.
- Accepts one memory op per handshake from the MEM-stage control (LB/LH/LW/LBU/LHU/SB/SH/SW).
- Drives the memory's word-wide, byte-addressed port using word-aligned addresses. Performs read-modify-write for sub-word stores, plus sign/zero extension and alignment/range checks.
- Returns the result through a valid/ready response channel.

---
 rtl/dmem_access_unit.sv | 152 +++++++++++++++
 tb/tb_dmem_access_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_unit.sv
// Load/store front-end for the word-wide, byte-addressed data memory: extend, align-check, sub-word RMW.
// Latency accept->resp_valid: loads/SW 2 cycles, SB/SH 3 cycles, errors 1 cycle.
// Backpressure: response held stable until i_resp_ready; o_req_ready only in IDLE.
module dmem_access_unit #(
  parameter int MEM_BYTES   = 256,
  parameter bit ZERO_ON_ERR = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [3:0]  i_req_op,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wData,
  output logic        o_resp_valid,
  input  logic        i_resp_ready,
  output logic [31:0] o_resp_rData,
  output logic        o_resp_err,
  output logic        o_DMem_we,
  output logic [31:0] o_DMem_addr,
  output logic [31:0] o_DMem_wData,
  input  logic [31:0] i_DMem_rData
);

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  state_t      state, state_nxt;
  logic [3:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] merged_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        req_err;
  logic [32:0] end_addr;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_ext;
  logic [31:0] merge_word;
  logic        dmem_we;
  logic [31:0] dmem_wdata;

  // Range check on the aligned base in 33 bits so a top-of-space address cannot wrap to "in range".
  always_comb begin
    end_addr = {1'b0, i_req_addr[31:2], 2'b00} + 33'd3;
    req_err  = (i_req_op[1:0] == SZ_RSVD)
            || ((i_req_op[1:0] == SZ_HALF) && i_req_addr[0])
            || ((i_req_op[1:0] == SZ_WORD) && (i_req_addr[1:0] != 2'b00))
            || (end_addr >= 33'(MEM_BYTES));
  end

  always_comb begin
    ld_byte = i_DMem_rData[{addr_q[1:0], 3'b000} +: 8];
    ld_half = addr_q[1] ? i_DMem_rData[31:16] : i_DMem_rData[15:0];
    case (op_q[1:0])
      SZ_BYTE: load_ext = {{24{~op_q[2] & ld_byte[7]}}, ld_byte};
      SZ_HALF: load_ext = {{16{~op_q[2] & ld_half[15]}}, ld_half};
      default: load_ext = i_DMem_rData;
    endcase
  end

  always_comb begin
    merge_word = i_DMem_rData;
    if (op_q[1:0] == SZ_BYTE) begin
      merge_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else if (addr_q[1]) begin
      merge_word[31:16] = wdata_q[15:0];
    end else begin
      merge_word[15:0] = wdata_q[15:0];
    end
  end

  always_comb begin
    state_nxt  = state;
    dmem_we    = 1'b0;
    dmem_wdata = 32'd0;
    case (state)
      IDLE: begin
        if (i_req_valid) state_nxt = req_err ? RESP : ACCESS;
      end
      ACCESS: begin
        if (op_q[3] && (op_q[1:0] == SZ_WORD)) begin
          dmem_we    = 1'b1;
          dmem_wdata = wdata_q;
          state_nxt  = RESP;
        end else if (op_q[3]) begin
          state_nxt  = WRITE;
        end else begin
          state_nxt  = RESP;
        end
      end
      WRITE: begin
        dmem_we    = 1'b1;
        dmem_wdata = merged_q;
        state_nxt  = RESP;
      end
      RESP: begin
        if (i_resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= 4'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      merged_q <= 32'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (i_req_valid) begin
            op_q    <= i_req_op;
            addr_q  <= i_req_addr;
            wdata_q <= i_req_wData;
            err_q   <= req_err;
            if (req_err && ZERO_ON_ERR) rdata_q <= 32'd0;
          end
        end
        ACCESS: begin
          if (op_q[3]) begin
            rdata_q  <= 32'd0;
            merged_q <= merge_word;
          end else begin
            rdata_q  <= load_ext;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_req_ready  = (state == IDLE);
  assign o_resp_valid = (state == RESP);
  assign o_resp_rData = rdata_q;
  assign o_resp_err   = err_q;
  assign o_DMem_addr  = {addr_q[31:2], 2'b00};
  assign o_DMem_wData = dmem_wdata;
  assign o_DMem_we    = dmem_we & ~rst;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit with a byte-array memory model behind the DMem port.
module tb_dmem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic [3:0]  i_req_op = 4'd0;
  logic [31:0] i_req_addr = 32'd0;
  logic [31:0] i_req_wData = 32'd0;
  logic        o_resp_valid;
  logic        i_resp_ready = 1'b0;
  logic [31:0] o_resp_rData;
  logic        o_resp_err;
  logic        o_DMem_we;
  logic [31:0] o_DMem_addr;
  logic [31:0] o_DMem_wData;
  logic [31:0] i_DMem_rData;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;

  logic [7:0] mem [0:255];

  localparam logic [3:0] OP_LB  = 4'b0000;
  localparam logic [3:0] OP_LH  = 4'b0001;
  localparam logic [3:0] OP_LW  = 4'b0010;
  localparam logic [3:0] OP_RSV = 4'b0011;
  localparam logic [3:0] OP_LBU = 4'b0100;
  localparam logic [3:0] OP_LHU = 4'b0101;
  localparam logic [3:0] OP_SB  = 4'b1000;
  localparam logic [3:0] OP_SH  = 4'b1001;
  localparam logic [3:0] OP_SW  = 4'b1010;

  dmem_access_unit #(.MEM_BYTES(256), .ZERO_ON_ERR(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_op     (i_req_op),
    .i_req_addr   (i_req_addr),
    .i_req_wData  (i_req_wData),
    .o_resp_valid (o_resp_valid),
    .i_resp_ready (i_resp_ready),
    .o_resp_rData (o_resp_rData),
    .o_resp_err   (o_resp_err),
    .o_DMem_we    (o_DMem_we),
    .o_DMem_addr  (o_DMem_addr),
    .o_DMem_wData (o_DMem_wData),
    .i_DMem_rData (i_DMem_rData)
  );

  always #5 clk = ~clk;

  always_comb begin
    i_DMem_rData = 32'd0;
    if (o_DMem_addr < 32'd256)
      i_DMem_rData = {mem[o_DMem_addr[7:0] + 8'd3], mem[o_DMem_addr[7:0] + 8'd2],
                      mem[o_DMem_addr[7:0] + 8'd1], mem[o_DMem_addr[7:0]]};
  end

  always @(posedge clk) begin
    if (o_DMem_we) begin
      we_cnt <= we_cnt + 1;
      if (o_DMem_addr < 32'd256) begin
        mem[o_DMem_addr[7:0]]        <= o_DMem_wData[7:0];
        mem[o_DMem_addr[7:0] + 8'd1] <= o_DMem_wData[15:8];
        mem[o_DMem_addr[7:0] + 8'd2] <= o_DMem_wData[23:16];
        mem[o_DMem_addr[7:0] + 8'd3] <= o_DMem_wData[31:24];
      end
    end
  end

  // Presents one request for exactly one accept edge; caller guarantees IDLE.
  task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    i_req_op    = op;
    i_req_addr  = addr;
    i_req_wData = wd;
    i_req_valid = 1'b1;
    @(posedge clk);
    #1 i_req_valid = 1'b0;
  endtask

  // Cycles after the accept edge until resp_valid seen at a negedge; 99 on timeout.
  task automatic wait_resp(output int lat);
    lat = 99;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (o_resp_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic finish_resp();
    @(negedge clk);
    i_resp_ready = 1'b1;
    @(posedge clk);
    #1 i_resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (o_DMem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", o_DMem_we); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (o_req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", o_req_ready); end
    checks++; if (o_resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", o_resp_valid); end
    checks++; if (o_resp_rData !== 32'd0) begin errors++; $display("FAIL reset_rData: got %h want 0", o_resp_rData); end
    checks++; if (o_resp_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", o_resp_err); end
    checks++; if (o_DMem_addr !== 32'd0) begin errors++; $display("FAIL reset_addr: got %h want 0", o_DMem_addr); end
    checks++; if (o_DMem_wData !== 32'd0) begin errors++; $display("FAIL reset_wData: got %h want 0", o_DMem_wData); end
  endtask

  task automatic test_loads();
    logic [3:0]  ops  [8] = '{OP_LB, OP_LBU, OP_LH, OP_LW, OP_LW, OP_LHU, OP_LH, OP_LB};
    logic [31:0] adrs [8] = '{32'h13, 32'h13, 32'h12, 32'h10, 32'hFC, 32'hFE, 32'hFC, 32'h11};
    logic [31:0] exps [8] = '{32'hFFFFFF88, 32'h00000088, 32'hFFFF8899, 32'h8899AABB,
                              32'h04030201, 32'h00000403, 32'h00000201, 32'hFFFFFFAA};
    int lat;
    for (int i = 0; i < 8; i++) begin
      issue(ops[i], adrs[i], 32'hCAFEF00D);
      wait_resp(lat);
      checks++; if (lat != 2) begin errors++; $display("FAIL load%0d_latency: got %0d want 2", i, lat); end
      checks++; if (o_resp_rData !== exps[i]) begin errors++; $display("FAIL load%0d_rData: got %h want %h", i, o_resp_rData, exps[i]); end
      checks++; if (o_resp_err !== 1'b0) begin errors++; $display("FAIL load%0d_err: got %b want 0", i, o_resp_err); end
      finish_resp();
    end
  endtask

  task automatic test_sub_word_store();
    int w0, lat;
    w0 = we_cnt;
    issue(OP_SB, 32'h11, 32'h12345677);
    @(negedge clk);
    checks++; if (o_DMem_we !== 1'b0) begin errors++; $display("FAIL sb_access_we: got %b want 0", o_DMem_we); end
    @(negedge clk);
    checks++; if (o_DMem_we !== 1'b1) begin errors++; $display("FAIL sb_write_we: got %b want 1", o_DMem_we); end
    checks++; if (o_DMem_addr !== 32'h10) begin errors++; $display("FAIL sb_write_addr: got %h want 00000010", o_DMem_addr); end
    checks++; if (o_DMem_wData !== 32'h889977BB) begin errors++; $display("FAIL sb_write_wData: got %h want 889977bb", o_DMem_wData); end
    @(negedge clk);
    checks++; if (o_resp_valid !== 1'b1) begin errors++; $display("FAIL sb_latency3: got valid=%b want 1", o_resp_valid); end
    checks++; if (o_resp_rData !== 32'd0 || o_resp_err !== 1'b0) begin errors++; $display("FAIL sb_resp: got %h/%b want 0/0", o_resp_rData, o_resp_err); end
    finish_resp();
    checks++; if (we_cnt - w0 != 1) begin errors++; $display("FAIL sb_we_pulses: got %0d want 1", we_cnt - w0); end
    issue(OP_LW, 32'h10, 32'd0);
    wait_resp(lat);
    checks++; if (o_resp_rData !== 32'h889977BB) begin errors++; $display("FAIL sb_readback: got %h want 889977bb", o_resp_rData); end
    finish_resp();
    issue(OP_SW, 32'h20, 32'hDEADBEEF);
    wait_resp(lat);
    checks++; if (lat != 2) begin errors++; $display("FAIL sw_latency: got %0d want 2", lat); end
    checks++; if (o_resp_rData !== 32'd0) begin errors++; $display("FAIL sw_rData: got %h want 0", o_resp_rData); end
    finish_resp();
    issue(OP_SH, 32'h22, 32'hFFFF5A5A);
    wait_resp(lat);
    checks++; if (lat != 3) begin errors++; $display("FAIL sh_latency: got %0d want 3", lat); end
    finish_resp();
    issue(OP_LW, 32'h20, 32'd0);
    wait_resp(lat);
    checks++; if (o_resp_rData !== 32'h5A5ABEEF) begin errors++; $display("FAIL sh_readback: got %h want 5a5abeef", o_resp_rData); end
    finish_resp();
  endtask

  task automatic test_errors();
    logic [3:0]  ops  [5] = '{OP_SH, OP_LW, OP_LW, OP_LW, OP_RSV};
    logic [31:0] adrs [5] = '{32'h11, 32'h102, 32'hFD, 32'h100, 32'h10};
    int w0, lat;
    w0 = we_cnt;
    for (int i = 0; i < 5; i++) begin
      issue(ops[i], adrs[i], 32'hFFFFFFFF);
      wait_resp(lat);
      checks++; if (lat != 1) begin errors++; $display("FAIL err%0d_latency: got %0d want 1", i, lat); end
      checks++; if (o_resp_err !== 1'b1) begin errors++; $display("FAIL err%0d_flag: got %b want 1", i, o_resp_err); end
      checks++; if (o_resp_rData !== 32'd0) begin errors++; $display("FAIL err%0d_rData: got %h want 0", i, o_resp_rData); end
      finish_resp();
    end
    checks++; if (we_cnt != w0) begin errors++; $display("FAIL err_no_write: got %0d writes want 0", we_cnt - w0); end
    issue(OP_LW, 32'h10, 32'd0);
    wait_resp(lat);
    checks++; if (o_resp_rData !== 32'h889977BB) begin errors++; $display("FAIL err_mem_unchanged: got %h want 889977bb", o_resp_rData); end
    finish_resp();
  endtask

  task automatic test_backpressure();
    int w0, lat;
    w0 = we_cnt;
    issue(OP_LW, 32'h10, 32'd0);
    wait_resp(lat);
    @(negedge clk);
    i_req_op = OP_SW; i_req_addr = 32'h10; i_req_wData = 32'd0; i_req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (o_resp_valid !== 1'b1 || o_resp_rData !== 32'h889977BB || o_req_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d: got v=%b d=%h rdy=%b want 1/889977bb/0", c, o_resp_valid, o_resp_rData, o_req_ready);
      end
    end
    i_resp_ready = 1'b1;
    @(negedge clk);
    i_resp_ready = 1'b0;
    checks++; if (o_resp_valid !== 1'b0 || o_req_ready !== 1'b1) begin
      errors++; $display("FAIL bp_after_handshake: got v=%b rdy=%b want 0/1", o_resp_valid, o_req_ready);
    end
    i_req_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (we_cnt != w0 || o_resp_valid !== 1'b0) begin
      errors++; $display("FAIL bp_req_ignored: got writes=%0d v=%b want 0/0", we_cnt - w0, o_resp_valid);
    end
  endtask

  task automatic test_reset_mid_write();
    int w0, lat;
    w0 = we_cnt;
    issue(OP_SH, 32'h20, 32'h00001234);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (o_DMem_we !== 1'b0) begin errors++; $display("FAIL rstmid_we: got %b want 0", o_DMem_we); end
    @(negedge clk);
    rst = 1'b0;
    checks++; if (o_req_ready !== 1'b1 || o_resp_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_idle: got rdy=%b v=%b want 1/0", o_req_ready, o_resp_valid);
    end
    repeat (4) @(negedge clk);
    checks++; if (o_resp_valid !== 1'b0 || we_cnt != w0) begin
      errors++; $display("FAIL rstmid_no_resp: got v=%b writes=%0d want 0/0", o_resp_valid, we_cnt - w0);
    end
    issue(OP_LW, 32'h20, 32'd0);
    wait_resp(lat);
    checks++; if (o_resp_rData !== 32'h5A5ABEEF) begin errors++; $display("FAIL rstmid_mem: got %h want 5a5abeef", o_resp_rData); end
    finish_resp();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[16] = 8'hBB; mem[17] = 8'hAA; mem[18] = 8'h99; mem[19] = 8'h88;
    mem[252] = 8'h01; mem[253] = 8'h02; mem[254] = 8'h03; mem[255] = 8'h04;
    test_reset();
    test_loads();
    test_sub_word_store();
    test_errors();
    test_backpressure();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
